// File: rtl/bus_pkg.sv
// Shared definitions for the bus source decoder: FSM state encoding,
// code width and number of bus sources.
package bus_pkg;

  localparam int CODE_W = 5;
  localparam int SRC_N  = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_decode_5to32.sv
// Purely combinational 5-to-32 one-hot decoder used by the drive_en register
// stage of bus_source_decoder.
module onehot_decode_5to32
  import bus_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SRC_N-1:0]  onehot
);

  // Exactly one bit set, selected by the source index.
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/bus_source_decoder.sv
// Bus source decoder: accepts a 5-bit source index over a valid/ready
// handshake and drives the matching one-hot output enable for HOLD cycles.
// Optional feature macro: BUS_DECODER_GAP_EN inserts one bus-turnaround GAP
// cycle (drive_en all-zero, code_ready low) after every drive period and
// after a flush out of DRIVE.
module bus_source_decoder
  import bus_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              flush,
  output logic [SRC_N-1:0]  drive_en,
  output logic              busy,
  output logic [15:0]       grant_count
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [SRC_N-1:0]   decoded;
  logic               accept;
  logic               last_drive;

  onehot_decode_5to32 u_decode (
    .code   (code_in),
    .onehot (decoded)
  );

  // Ready is derived purely from registered state; a new code may enter from
  // IDLE, or (without the turnaround gap) in the final cycle of a drive period.
  always_comb begin
    last_drive = (state == DRIVE) && (hold_cnt == '0);
`ifdef BUS_DECODER_GAP_EN
    code_ready = (state == IDLE);
`else
    code_ready = (state == IDLE) || last_drive;
`endif
    busy   = (state != IDLE);
    accept = code_valid && code_ready && !flush;
  end

  // Single FSM register: reset beats flush, flush beats any handshake.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      drive_en    <= '0;
      hold_cnt    <= '0;
      grant_count <= '0;
    end else if (flush) begin
`ifdef BUS_DECODER_GAP_EN
      state       <= (state == DRIVE) ? GAP : IDLE;
`else
      state       <= IDLE;
`endif
      drive_en    <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= DRIVE;
            drive_en    <= decoded;
            hold_cnt    <= HOLD_LOAD;
            grant_count <= grant_count + 16'd1;
          end
        end
        DRIVE: begin
          if (!last_drive) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end else begin
`ifdef BUS_DECODER_GAP_EN
            state    <= GAP;
            drive_en <= '0;
`else
            if (accept) begin
              state       <= DRIVE;
              drive_en    <= decoded;
              hold_cnt    <= HOLD_LOAD;
              grant_count <= grant_count + 16'd1;
            end else begin
              state    <= IDLE;
              drive_en <= '0;
            end
`endif
          end
        end
        GAP: begin
          state    <= IDLE;
          drive_en <= '0;
        end
        default: begin
          state    <= IDLE;
          drive_en <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_decoder.sv
// Directed testbench for bus_source_decoder. Three instances with HOLD = 3, 1
// and 2 share clock and reset but have independent stimulus. Builds with and
// without BUS_DECODER_GAP_EN.
module tb_bus_source_decoder;

  logic        clock;
  logic        reset_n;

  logic [4:0]  codeA, codeB, codeC;
  logic        validA, validB, validC;
  logic        flushA, flushB, flushC;
  logic        readyA, readyB, readyC;
  logic        busyA, busyB, busyC;
  logic [31:0] driveA, driveB, driveC;
  logic [15:0] grantA, grantB, grantC;

  int assertCount = 0;
  int failCount   = 0;

  bus_source_decoder #(.HOLD(3)) dutA (
    .clock(clock), .reset_n(reset_n), .code_in(codeA), .code_valid(validA),
    .code_ready(readyA), .flush(flushA), .drive_en(driveA), .busy(busyA),
    .grant_count(grantA)
  );

  bus_source_decoder #(.HOLD(1)) dutB (
    .clock(clock), .reset_n(reset_n), .code_in(codeB), .code_valid(validB),
    .code_ready(readyB), .flush(flushB), .drive_en(driveB), .busy(busyB),
    .grant_count(grantB)
  );

  bus_source_decoder #(.HOLD(2)) dutC (
    .clock(clock), .reset_n(reset_n), .code_in(codeC), .code_valid(validC),
    .code_ready(readyC), .flush(flushC), .drive_en(driveC), .busy(busyC),
    .grant_count(grantC)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the inputs of one instance (0 = A, 1 = B, 2 = C).
  task automatic applyStimulus(input int sel, input logic v, input logic [4:0] c,
                               input logic f);
    case (sel)
      0: begin validA = v; codeA = c; flushA = f; end
      1: begin validB = v; codeB = c; flushB = f; end
      default: begin validC = v; codeC = c; flushC = f; end
    endcase
  endtask

  // Advance past the next rising edge; sampling happens 1 unit after it.
  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  // Directed sequence.
  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1'b1, 5'd3, 1'b0);
    applyStimulus(1, 1'b1, 5'd3, 1'b0);
    applyStimulus(2, 1'b1, 5'd3, 1'b0);

    // Reset held two cycles with code_valid high.
    waitCycle();
    waitCycle();
    checkOutput("rst_drive", driveA, 32'h0);
    checkOutput("rst_grant", {16'h0, grantA}, 32'h0);
    checkOutput("rst_busy", {31'h0, busyA}, 32'h0);
    reset_n = 1'b1;
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1, 1'b0, 5'd0, 1'b0);
    applyStimulus(2, 1'b0, 5'd0, 1'b0);
    checkOutput("rst_ready", {31'h0, readyA}, 32'h1);

    // Single grant, HOLD=3, code 7.
    applyStimulus(0, 1'b1, 5'd7, 1'b0);
    waitCycle();
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    checkOutput("single_c1", driveA, 32'h0000_0080);
    checkOutput("single_busy", {31'h0, busyA}, 32'h1);
    checkOutput("single_ready", {31'h0, readyA}, 32'h0);
    waitCycle();
    checkOutput("single_c2", driveA, 32'h0000_0080);
    waitCycle();
    checkOutput("single_c3", driveA, 32'h0000_0080);
    waitCycle();
    checkOutput("single_end", driveA, 32'h0);
    checkOutput("single_grant", {16'h0, grantA}, 32'h1);
`ifdef BUS_DECODER_GAP_EN
    checkOutput("single_gap_ready", {31'h0, readyA}, 32'h0);
    checkOutput("single_gap_busy", {31'h0, busyA}, 32'h1);
    waitCycle();
`endif
    checkOutput("single_idle_ready", {31'h0, readyA}, 32'h1);
    checkOutput("single_idle_busy", {31'h0, busyA}, 32'h0);

    // Flush beats a simultaneous valid code in IDLE.
    applyStimulus(0, 1'b1, 5'd3, 1'b1);
    waitCycle();
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    checkOutput("flush_idle_grant", {16'h0, grantA}, 32'h1);
    checkOutput("flush_idle_drive", driveA, 32'h0);
    checkOutput("flush_idle_busy", {31'h0, busyA}, 32'h0);

    // Flush in the middle of driving code 9.
    applyStimulus(0, 1'b1, 5'd9, 1'b0);
    waitCycle();
    checkOutput("flush_drv_pre", driveA, 32'h0000_0200);
    checkOutput("flush_drv_grant", {16'h0, grantA}, 32'h2);
    applyStimulus(0, 1'b1, 5'd9, 1'b1);
    waitCycle();
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    checkOutput("flush_drv_drive", driveA, 32'h0);
    checkOutput("flush_drv_grant2", {16'h0, grantA}, 32'h2);
`ifdef BUS_DECODER_GAP_EN
    checkOutput("flush_drv_gap_busy", {31'h0, busyA}, 32'h1);
    checkOutput("flush_drv_gap_ready", {31'h0, readyA}, 32'h0);
    waitCycle();
`endif
    checkOutput("flush_drv_busy", {31'h0, busyA}, 32'h0);

    // IDLE with code_valid low holds everything.
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("idle_hold_drive", driveA, 32'h0);
      checkOutput("idle_hold_grant", {16'h0, grantA}, 32'h2);
    end

`ifndef BUS_DECODER_GAP_EN
    // Back-to-back grants, HOLD=1: code 0 then code 31, no zero cycle.
    applyStimulus(1, 1'b1, 5'd0, 1'b0);
    waitCycle();
    checkOutput("b2b_first", driveB, 32'h0000_0001);
    checkOutput("b2b_ready", {31'h0, readyB}, 32'h1);
    applyStimulus(1, 1'b1, 5'd31, 1'b0);
    waitCycle();
    applyStimulus(1, 1'b0, 5'd0, 1'b0);
    checkOutput("b2b_second", driveB, 32'h8000_0000);
    checkOutput("b2b_grant", {16'h0, grantB}, 32'h2);
    waitCycle();
    checkOutput("b2b_end", driveB, 32'h0);

    // Wrap-around: continuous accepts up to 0xFFFF, then one more.
    applyStimulus(1, 1'b1, 5'd12, 1'b0);
    repeat (65533) waitCycle();
    checkOutput("wrap_ffff", {16'h0, grantB}, 32'h0000_FFFF);
    checkOutput("wrap_drive", driveB, 32'h0000_1000);
    waitCycle();
    applyStimulus(1, 1'b0, 5'd0, 1'b0);
    checkOutput("wrap_zero", {16'h0, grantB}, 32'h0);
`else
    // Gap, HOLD=2: code 4 then code 5 held valid.
    applyStimulus(2, 1'b1, 5'd4, 1'b0);
    waitCycle();
    applyStimulus(2, 1'b1, 5'd5, 1'b0);
    checkOutput("gap_c4_1", driveC, 32'h0000_0010);
    waitCycle();
    checkOutput("gap_c4_2", driveC, 32'h0000_0010);
    waitCycle();
    checkOutput("gap_zero", driveC, 32'h0);
    checkOutput("gap_ready", {31'h0, readyC}, 32'h0);
    checkOutput("gap_busy", {31'h0, busyC}, 32'h1);
    waitCycle();
    checkOutput("gap_idle_drive", driveC, 32'h0);
    checkOutput("gap_idle_ready", {31'h0, readyC}, 32'h1);
    waitCycle();
    applyStimulus(2, 1'b0, 5'd0, 1'b0);
    checkOutput("gap_c5_1", driveC, 32'h0000_0020);
    waitCycle();
    checkOutput("gap_c5_2", driveC, 32'h0000_0020);
    checkOutput("gap_grant", {16'h0, grantC}, 32'h2);
`endif

    // Reset overrides a grant in progress.
    applyStimulus(0, 1'b1, 5'd1, 1'b0);
    waitCycle();
    checkOutput("rst_mid_pre", driveA, 32'h0000_0002);
    checkOutput("rst_mid_grant_pre", {16'h0, grantA}, 32'h3);
    reset_n = 1'b0;
    applyStimulus(0, 1'b1, 5'd2, 1'b1);
    waitCycle();
    checkOutput("rst_mid_drive", driveA, 32'h0);
    checkOutput("rst_mid_grant", {16'h0, grantA}, 32'h0);
    checkOutput("rst_mid_busy", {31'h0, busyA}, 32'h0);
    reset_n = 1'b1;
    applyStimulus(0, 1'b0, 5'd0, 1'b0);
    checkOutput("rst_mid_ready", {31'h0, readyA}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
